signal_engine: RTL and testbench

- Downstream consumer of the Q16.16 feature stream (ret, ema) produced by the feature extraction stage.
- Runs a hysteresis position state machine (FLAT/LONG/SHORT) with a post-exit cooldown.
- Emits buy/sell orders on a valid/ready stream toward the order gateway.
- Sits between feature extraction and order management. It provides backpressure upstream and holds one registered order slot.

---
 rtl/signal_engine.sv | 141 ++++++++++++++
 tb/tb_signal_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_engine.sv
// Hysteresis position engine: turns the Q16.16 (ret, ema) feature stream into
// buy/sell orders through a single registered order slot, with post-exit cooldown.
module signal_engine #(
  parameter logic signed [31:0] ENTRY_TH = 32'sh0000_0800,
  parameter logic signed [31:0] EXIT_TH  = 32'sh0000_0200,
  parameter int unsigned        HOLDOFF  = 4,
  parameter int unsigned        QTY      = 1,
  localparam int unsigned       CW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               feat_valid,
  output logic               feat_ready,
  input  logic signed [31:0] ret_in,
  input  logic signed [31:0] ema_in,
  input  logic               halt,
  output logic               order_valid,
  input  logic               order_ready,
  output logic               order_side,
  output logic [7:0]         order_qty,
  output logic [15:0]        order_seq,
  output logic [1:0]         pos_state,
  output logic [CW-1:0]      cooldown
);

  typedef enum logic [1:0] {
    FLAT  = 2'b00,
    LONG  = 2'b01,
    SHORT = 2'b10
  } state_t;

  localparam logic signed [31:0] NEG_ENTRY = -ENTRY_TH;
  localparam logic signed [31:0] NEG_EXIT  = -EXIT_TH;
  localparam logic [CW-1:0]      HOLD      = CW'(HOLDOFF);
  localparam logic [7:0]         QTY1      = 8'(QTY);
  localparam logic [7:0]         QTY2      = 8'(2 * QTY);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cd_nxt;
  logic          emit;
  logic          emit_side;
  logic [7:0]    emit_qty;
  logic          slot_free;
  logic          accept;

  assign slot_free  = !order_valid || order_ready;
  assign feat_ready = slot_free && !halt;
  assign accept     = feat_valid && feat_ready;
  assign pos_state  = state;

  // halt never coexists with accept, so the flatten path and the sample path are exclusive
  always_comb begin
    state_nxt = state;
    cd_nxt    = cooldown;
    emit      = 1'b0;
    emit_side = 1'b0;
    emit_qty  = '0;
    if (halt) begin
      if (state != FLAT && slot_free) begin
        emit      = 1'b1;
        emit_side = (state == SHORT);
        emit_qty  = QTY1;
        state_nxt = FLAT;
        cd_nxt    = HOLD;
      end
    end else if (accept) begin
      cd_nxt = (cooldown != '0) ? cooldown - CW'(1) : cooldown;
      case (state)
        FLAT: begin
          if (cooldown == '0) begin
            if (ema_in > ENTRY_TH && ret_in >= 32'sd0) begin
              emit      = 1'b1;
              emit_side = 1'b1;
              emit_qty  = QTY1;
              state_nxt = LONG;
            end else if (ema_in < NEG_ENTRY && ret_in <= 32'sd0) begin
              emit      = 1'b1;
              emit_side = 1'b0;
              emit_qty  = QTY1;
              state_nxt = SHORT;
            end
          end
        end
        LONG: begin
          if (ema_in < NEG_ENTRY) begin
            emit      = 1'b1;
            emit_side = 1'b0;
            emit_qty  = QTY2;
            state_nxt = SHORT;
          end else if (ema_in < EXIT_TH) begin
            emit      = 1'b1;
            emit_side = 1'b0;
            emit_qty  = QTY1;
            state_nxt = FLAT;
            cd_nxt    = HOLD;
          end
        end
        SHORT: begin
          if (ema_in > ENTRY_TH) begin
            emit      = 1'b1;
            emit_side = 1'b1;
            emit_qty  = QTY2;
            state_nxt = LONG;
          end else if (ema_in > NEG_EXIT) begin
            emit      = 1'b1;
            emit_side = 1'b1;
            emit_qty  = QTY1;
            state_nxt = FLAT;
            cd_nxt    = HOLD;
          end
        end
        default: state_nxt = FLAT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FLAT;
      cooldown    <= '0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_qty   <= '0;
      order_seq   <= '0;
    end else begin
      state    <= state_nxt;
      cooldown <= cd_nxt;
      // emit is only possible with a free slot, so loading here also covers consume+emit
      if (emit) begin
        order_valid <= 1'b1;
        order_side  <= emit_side;
        order_qty   <= emit_qty;
        order_seq   <= order_seq + 16'd1;
      end else if (order_ready) begin
        order_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_signal_engine.sv
// Bench for signal_engine: directed scenarios plus random traffic, every cycle
// compared against a behavioural position/order model.
module tb_signal_engine;

  localparam int ENTRY = 'h800;
  localparam int EXITT = 'h200;
  localparam int HOLD  = 4;
  localparam int Q     = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        feat_valid;
  logic        feat_ready;
  logic [31:0] ret_in;
  logic [31:0] ema_in;
  logic        halt;
  logic        order_valid;
  logic        order_ready;
  logic        order_side;
  logic [7:0]  order_qty;
  logic [15:0] order_seq;
  logic [1:0]  pos_state;
  logic [2:0]  cooldown;

  int n_assert = 0;
  int n_fail   = 0;

  // model: position 0=FLAT 1=LONG 2=SHORT, plus the order slot contents
  int m_state, m_cd, m_qty, m_seq;
  bit m_ov, m_side;

  signal_engine #(
    .ENTRY_TH(32'sh0000_0800),
    .EXIT_TH (32'sh0000_0200),
    .HOLDOFF (4),
    .QTY     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .ret_in     (ret_in),
    .ema_in     (ema_in),
    .halt       (halt),
    .order_valid(order_valid),
    .order_ready(order_ready),
    .order_side (order_side),
    .order_qty  (order_qty),
    .order_seq  (order_seq),
    .pos_state  (pos_state),
    .cooldown   (cooldown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_qty = 0; m_seq = 0; m_ov = 0; m_side = 0;
  endtask

  task automatic emit_order(input bit side, input int qty);
    m_ov   = 1;
    m_side = side;
    m_qty  = qty;
    m_seq  = (m_seq + 1) % 65536;
  endtask

  task automatic check_all();
    chk("order_valid", order_valid, m_ov);
    chk("pos_state", pos_state, m_state);
    chk("cooldown", cooldown, m_cd);
    chk("order_side", order_side, m_side);
    chk("order_qty", order_qty, m_qty);
    chk("order_seq", order_seq, m_seq);
  endtask

  // one clock with the currently driven inputs; model advances on the same edge
  task automatic step();
    bit free, rdy, emitted;
    int e, r, cd0;
    #1;
    free = !m_ov || order_ready;
    rdy  = free && !halt;
    chk("feat_ready", feat_ready, rdy);
    @(posedge clk);
    e = $signed(ema_in);
    r = $signed(ret_in);
    emitted = 0;
    if (halt) begin
      if (m_state != 0 && free) begin
        emit_order(m_state == 2, Q);
        emitted = 1;
        m_state = 0;
        m_cd = HOLD;
      end
    end else if (feat_valid && rdy) begin
      cd0 = m_cd;
      if (m_cd > 0) m_cd--;
      if (m_state == 0 && cd0 == 0 && e > ENTRY && r >= 0) begin
        emit_order(1, Q); emitted = 1; m_state = 1;
      end else if (m_state == 0 && cd0 == 0 && e < -ENTRY && r <= 0) begin
        emit_order(0, Q); emitted = 1; m_state = 2;
      end else if (m_state == 1 && e < -ENTRY) begin
        emit_order(0, 2 * Q); emitted = 1; m_state = 2;
      end else if (m_state == 1 && e < EXITT) begin
        emit_order(0, Q); emitted = 1; m_state = 0; m_cd = HOLD;
      end else if (m_state == 2 && e > ENTRY) begin
        emit_order(1, 2 * Q); emitted = 1; m_state = 1;
      end else if (m_state == 2 && e > -EXITT) begin
        emit_order(1, Q); emitted = 1; m_state = 0; m_cd = HOLD;
      end
    end
    if (!emitted && m_ov && order_ready) m_ov = 0;
    #1;
    check_all();
  endtask

  task automatic sample(input int ema, input int ret);
    feat_valid = 1;
    ema_in = ema;
    ret_in = ret;
    step();
  endtask

  function automatic logic [31:0] pick_ema();
    case ($urandom_range(0, 15))
      0: return 32'h0000_0800;  1: return 32'h0000_0801;
      2: return 32'h0000_07FF;  3: return 32'hFFFF_F800;
      4: return 32'hFFFF_F7FF;  5: return 32'hFFFF_F801;
      6: return 32'h0000_0200;  7: return 32'h0000_01FF;
      8: return 32'h0000_0201;  9: return 32'hFFFF_FE00;
      10: return 32'hFFFF_FE01; 11: return 32'hFFFF_FDFF;
      12: return 32'h0000_0000; 13: return 32'h0000_1000;
      14: return 32'hFFFF_F000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int prev;
    rst_n = 0; feat_valid = 0; ret_in = 0; ema_in = 0; halt = 0; order_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_feat_ready", feat_ready, 1);
    rst_n = 1;

    // entry, reversal, exit into cooldown, cooldown countdown, re-entry
    sample('h1000, 'h100);
    chk("entry_buy", {order_valid, order_side, order_qty, order_seq, pos_state},
        {1'b1, 1'b1, 8'd1, 16'd1, 2'b01});
    sample(-'h1000, 0);
    chk("reverse_sell2", {order_side, order_qty, order_seq, pos_state, cooldown},
        {1'b0, 8'd2, 16'd2, 2'b10, 3'd0});
    sample(0, 0);
    chk("exit_buy", {order_side, order_qty, pos_state, cooldown}, {1'b1, 8'd1, 2'b00, 3'd4});
    for (int i = 0; i < 4; i++) begin
      sample('h1000, 0);
      chk("cooldown_count", cooldown, 3 - i);
      chk("cooldown_no_order", order_valid, 0);
    end
    sample('h1000, 0);
    chk("reentry_buy", {order_valid, order_side, order_qty, pos_state}, {1'b1, 1'b1, 8'd1, 2'b01});

    // backpressure: pending order holds, then consume and accept in one cycle
    order_ready = 0;
    for (int i = 0; i < 10; i++) sample(0, 0);
    chk("bp_held_seq", order_seq, 16'd4);
    order_ready = 1;
    sample(0, 0);
    chk("bp_release_exit", {order_seq, order_side, pos_state, cooldown},
        {16'd5, 1'b0, 2'b00, 3'd4});
    for (int i = 0; i < 4; i++) sample(0, 0);
    sample('h1000, 0);

    // halt with a full slot: flatten waits for the slot, then fires once
    order_ready = 0;
    halt = 1;
    for (int i = 0; i < 3; i++) sample('hFFFF_F000, 0);
    chk("halt_wait_pos", pos_state, 2'b01);
    order_ready = 1;
    sample('hFFFF_F000, 0);
    chk("halt_flatten", {order_valid, order_side, order_qty, pos_state, cooldown},
        {1'b1, 1'b0, 8'd1, 2'b00, 3'd4});
    sample(0, 0);
    sample(0, 0);
    chk("halt_once", order_valid, 0);
    halt = 0;
    sample(0, 0);
    chk("halt_resume_cd", cooldown, 3'd3);

    // random traffic with boundary-heavy ema values
    for (int i = 0; i < 3000; i++) begin
      feat_valid  = ($urandom_range(0, 3) != 0);
      order_ready = ($urandom_range(0, 2) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      ema_in      = pick_ema();
      case ($urandom_range(0, 3))
        0: ret_in = 0;
        1: ret_in = 1;
        2: ret_in = 32'hFFFF_FFFF;
        default: ret_in = $urandom();
      endcase
      step();
    end

    // continuous reversals until the sequence number wraps
    halt = 0; order_ready = 1;
    for (int i = 0; i < 65546; i++) begin
      prev = m_seq;
      sample((m_state == 1) ? -'h1000 : 'h1000, 0);
      if (prev == 'hFFFF && m_seq == 0) chk("seq_wrap", order_seq, 16'h0000);
    end

    // asynchronous reset with an order pending
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", order_valid, 0);
    chk("async_rst_pos", pos_state, 2'b00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    feat_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
